// File: rtl/ex2_pkg.sv
// Shared definitions for the Ex2 xor-pack link: FSM state type, X field helpers and popcount.
// Helpers work on wide vectors plus a width argument so any W up to 64 can reuse them.
package ex2_pkg;

  localparam int W_DEF = 8;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } st_e;

  // X = {Y, Z}: Y occupies the upper half, Z the lower half.
  function automatic logic [127:0] pack_x(input logic [63:0] y, input logic [63:0] z,
                                          input int unsigned w);
    return (128'(y) << w) | 128'(z);
  endfunction

  function automatic logic [63:0] x_hi(input logic [127:0] x, input int unsigned w);
    return 64'(x >> w);
  endfunction

  function automatic logic [63:0] x_lo(input logic [127:0] x);
    return 64'(x);
  endfunction

  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/ex2_pipe_stage.sv
// Generic valid/ready register slice: loads when empty or when its content leaves this cycle.
// in_ready never looks at in_valid, so upstream may wait on it without a combinational loop.
module ex2_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/ex2_xor_decoder.sv
// Receive side of the Ex2 xor-pack link: strips the key, recovers a&b / a|b, the a/b difference
// mask and its popcount, flags inconsistent words and counts them, optionally halting on error.
module ex2_xor_decoder
  import ex2_pkg::*;
#(
  parameter int W           = W_DEF,
  parameter int ERR_CNT_W   = 8,
  parameter bit HALT_ON_ERR = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*W-1:0]         xor_in,
  input  logic [2*W-1:0]         c,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           and_ab,
  output logic [W-1:0]           or_ab,
  output logic [W-1:0]           diff_ab,
  output logic [$clog2(W+1)-1:0] diff_cnt,
  output logic                   err,
  output logic [ERR_CNT_W-1:0]   err_count,
  output logic                   halted,
  input  logic                   clr_err
);

  localparam int CW  = $clog2(W+1);
  localparam int S2W = 3*W + CW + 1;
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  st_e            state;
  logic           s1_in_valid;
  logic           s1_in_ready;
  logic           s1_valid;
  logic           s1_ready;
  logic [2*W-1:0] s1_q;
  logic [W-1:0]   y_c;
  logic [W-1:0]   z_c;
  logic [W-1:0]   diff_c;
  logic [CW-1:0]  cnt_c;
  logic           err_c;
  logic [S2W-1:0] s2_q;
  logic           err_xfer;

  // Valid/ready: a beat moves on a side when valid & ready are both high at the rising edge;
  // the payload is held while valid=1 and ready=0, and ready never depends on valid.
  assign s1_in_valid = in_valid & (state == RUN);
  assign in_ready    = (state == RUN) & s1_in_ready;

  ex2_pipe_stage #(.WIDTH(2*W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_in_valid),
    .in_ready  (s1_in_ready),
    .in_data   (xor_in ^ c),
    .out_valid (s1_valid),
    .out_ready (s1_ready),
    .out_data  (s1_q)
  );

  always_comb begin
    y_c    = W'(x_hi(128'(s1_q), W));
    z_c    = W'(x_lo(128'(s1_q)));
    diff_c = y_c ^ z_c;
    cnt_c  = CW'(popcount(64'(diff_c)));
    err_c  = |(y_c & ~z_c);
  end

  ex2_pipe_stage #(.WIDTH(S2W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s1_ready),
    .in_data   ({y_c, z_c, diff_c, cnt_c, err_c}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_q)
  );

  assign {and_ab, or_ab, diff_ab, diff_cnt, err} = s2_q;
  assign err_xfer = out_valid & out_ready & err;
  assign halted   = (state == HALT);

  // A clear landing with an errored delivery counts that delivery as the first new error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      err_count <= '0;
    end else begin
      if (err_xfer) begin
        if (clr_err)                    err_count <= ERR_CNT_W'(1);
        else if (err_count != CNT_MAX)  err_count <= err_count + 1'b1;
      end else if (clr_err) begin
        err_count <= '0;
      end

      if (err_xfer && HALT_ON_ERR) state <= HALT;
      else if (clr_err)            state <= RUN;
    end
  end

endmodule
